// File: rtl/eb_credit_tx.sv
// Credit-based link transmitter: turns a valid/ready stream into a ready-less link
// whose flow control is the remote receiver's credit returns.
module eb_credit_tx #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned CREDITS         = 4,
   parameter bit          GATING_FRIENDLY = 1'b1,
   localparam int unsigned CNT_W          = $clog2(CREDITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  link_valid,
   output logic [DATA_WIDTH-1:0] link_data,
   input  logic                  credit_in,
   output logic [CNT_W-1:0]      credit_cnt,
   output logic                  idle,
   output logic                  credit_err
);

   localparam logic [CNT_W-1:0] CreditsMax = CNT_W'(CREDITS);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  fire;

   // ready depends on registered count only, so no combinational path from credit_in
   assign ready_out = (cnt_q != '0);
   assign fire      = valid_in & ready_out;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      case ({fire, credit_in})
         2'b10: cnt_d = cnt_q - CNT_W'(1);
         2'b01: begin
            if (cnt_q == CreditsMax) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      data_d = data_in;
      if (GATING_FRIENDLY && !fire) begin
         data_d = data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= CreditsMax;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         valid_q <= fire;
         data_q  <= data_d;
      end
   end

   assign link_valid = valid_q;
   assign link_data  = data_q;
   assign credit_cnt = cnt_q;
   assign credit_err = err_q;
   assign idle       = (cnt_q == CreditsMax) & ~valid_q;

endmodule

// File: tb/tb_eb_credit_tx.sv
// Directed bench for eb_credit_tx: expected link payloads go through a scoreboard queue,
// status outputs are compared cycle by cycle against hand-computed values.
module tb_eb_credit_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic        ready_out;
   logic [15:0] data_in;
   logic        link_valid;
   logic [15:0] link_data;
   logic        credit_in;
   logic [2:0]  credit_cnt;
   logic        idle;
   logic        credit_err;

   logic        cr_man;
   logic        loop_en;
   logic        lv_d1, lv_d2;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_q[$];
   bit          prev_push = 1'b0;

   always #5 clk = ~clk;

   eb_credit_tx #(
      .DATA_WIDTH     (16),
      .CREDITS        (4),
      .GATING_FRIENDLY(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_in   (data_in),
      .link_valid(link_valid),
      .link_data (link_data),
      .credit_in (credit_in),
      .credit_cnt(credit_cnt),
      .idle      (idle),
      .credit_err(credit_err)
   );

   // Remote receiver model: returns a credit two cycles after each link pulse
   always @(posedge clk) begin
      lv_d1 <= link_valid;
      lv_d2 <= lv_d1;
   end
   assign credit_in = loop_en ? lv_d2 : cr_man;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // Monitor: every link pulse must match the oldest expected payload
   always @(negedge clk) begin
      if (link_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL link_unexpected at %0t: got %0h expected none", $time, link_data);
         end else begin
            check("link_data", int'(link_data), int'(exp_q.pop_front()));
         end
      end
   end

   // Checks current state, drives this cycle's inputs, advances one clock.
   task automatic cyc(input bit v, input logic [15:0] d, input bit cr, input int ecnt,
                      input bit eerr, input bit push);
      check("credit_cnt", int'(credit_cnt), ecnt);
      check("ready_out", int'(ready_out), int'(ecnt != 0));
      check("link_valid", int'(link_valid), int'(prev_push));
      check("idle", int'(idle), int'((ecnt == 4) && !prev_push));
      check("credit_err", int'(credit_err), int'(eerr));
      valid_in = v;
      data_in  = d;
      cr_man   = cr;
      if (push) exp_q.push_back(d);
      prev_push = push;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      cr_man   = 1'b0;
      loop_en  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_link_data", int'(link_data), 0);

      // Burst without credits: 1..4 go out, 5 is held upstream
      cyc(1, 16'h0001, 0, 4, 0, 1);
      cyc(1, 16'h0002, 0, 3, 0, 1);
      cyc(1, 16'h0003, 0, 2, 0, 1);
      cyc(1, 16'h0004, 0, 1, 0, 1);
      cyc(1, 16'h0005, 0, 0, 0, 0);
      cyc(1, 16'h0005, 0, 0, 0, 0);
      // One credit resumes the stream for exactly one item
      cyc(1, 16'h0005, 1, 0, 0, 0);
      cyc(1, 16'h0005, 0, 1, 0, 1);
      cyc(0, 16'h0000, 1, 0, 0, 0);
      check("link_data_hold", int'(link_data), 16'h0005);
      // Simultaneous fire and credit at cnt==1
      cyc(1, 16'h000a, 1, 1, 0, 1);
      cyc(0, 16'h0000, 1, 1, 0, 0);
      cyc(0, 16'h0000, 1, 2, 0, 0);
      cyc(0, 16'h0000, 1, 3, 0, 0);
      // Overflow at full count, then sticky error
      cyc(0, 16'h0000, 1, 4, 0, 0);
      cyc(0, 16'h0000, 0, 4, 1, 0);
      cyc(1, 16'h000b, 0, 4, 1, 1);
      // Reset mid-operation with an item on the link
      rst = 1'b1;
      cyc(0, 16'h0000, 0, 3, 1, 0);
      rst = 1'b0;
      cyc(0, 16'h0000, 0, 4, 0, 0);
      cyc(0, 16'h0000, 0, 4, 0, 0);
      cyc(0, 16'h0000, 0, 4, 0, 0);

      // Full throughput with looped-back credits (round trip 3, CREDITS 4)
      loop_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc(1, 16'h1000 + 16'(i), 0, (i < 3) ? 4 - i : 1, 0, 1);
      end
      cyc(0, 16'h0000, 0, 1, 0, 0);
      cyc(0, 16'h0000, 0, 2, 0, 0);
      cyc(0, 16'h0000, 0, 3, 0, 0);
      cyc(0, 16'h0000, 0, 4, 0, 0);
      loop_en = 1'b0;
      cyc(0, 16'h0000, 0, 4, 0, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eb_credit_tx.md
# eb_credit_tx

Credit-based link transmitter. It accepts a valid/ready elastic stream, as produced by the elastic buffers upstream, and drives it onto a point-to-point link that has no ready wire. The remote receiver returns one credit pulse per freed buffer slot. It sits at the sending end of long or pipelined inter-block channels, where a combinational ready path cannot be closed.

## Interface
Parameters:
- DATA_WIDTH, 16, payload width.
- CREDITS, 4, receiver buffer depth = initial credit count; legal range 1..255.
- GATING_FRIENDLY, 1'b1, 1: link_data loads only on accepted transfers; 0: link_data loads every cycle.
- CNT_W, $clog2(CREDITS+1), credit counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream item valid.
- ready_out  out  1  upstream may transfer; driven from registered state only.
- data_in  in  DATA_WIDTH  upstream payload.
- link_valid  out  1  one-cycle pulse per item sent on link; registered.
- link_data  out  DATA_WIDTH  payload qualified by link_valid; registered.
- credit_in  in  1  one pulse = one receiver slot freed.
- credit_cnt  out  CNT_W  current available credits (registered).
- idle  out  1  all credits home and no item in flight on output register.
- credit_err  out  1  sticky overflow error flag.

## Operation
- Clock is clk; reset is synchronous, active-high, on rst.
- Transfer: fire = valid_in & ready_out.
- ready_out = (credit_cnt != 0). It has no combinational dependence on credit_in or valid_in.
- Counter next value:
  - fire only: cnt-1.
  - credit_in only: cnt+1.
  - both: unchanged.
  - neither: unchanged.
- Overflow: credit_in with cnt==CREDITS and no fire.
  - Counter holds at CREDITS.
  - credit_err sets and stays set until rst.
- Underflow is impossible by construction, because fire requires cnt!=0.
- Output register:
  - link_valid <= fire every cycle.
  - link_data <= data_in when fire (GATING_FRIENDLY=1), or unconditionally (GATING_FRIENDLY=0).
  - With GATING_FRIENDLY=1, link_data holds its last sent value while link_valid=0.
- No back-pressure on link: the receiver must accept every link_valid pulse. Flow control is solely by credits.
- idle = (credit_cnt == CREDITS) & ~link_valid.
- Two-state credit-arithmetic view for verification: CREDITED (cnt>0, ready_out=1) and STARVED (cnt==0, ready_out=0).
  - CREDITED→STARVED on fire with cnt==1 and no credit_in.
  - STARVED→CREDITED on credit_in.

## Timing
- Reset values:
  - ready_out=1 (CREDITS≥1).
  - link_valid=0.
  - link_data=0.
  - credit_cnt=CREDITS.
  - idle=1.
  - credit_err=0.
- Latency: data_in at fire in cycle N appears as link_data with link_valid=1 in cycle N+1.
- Credit effect: credit_in in cycle N is reflected in credit_cnt/ready_out in cycle N+1. A stream stalled at cnt==0 resumes firing in N+1 at the earliest.
- Throughput: 1 item/cycle sustained iff CREDITS ≥ link round trip, measured as cycles from fire to corresponding credit_in, plus 1. Otherwise throughput is CREDITS per round trip.
- Simultaneous fire and credit_in at cnt==1: cnt stays 1, and ready_out stays 1 next cycle.
- Reset mid-operation:
  - Counter restores to CREDITS and link_valid drops in the next cycle.
  - In-flight credits arriving after reset count as overflow only if cnt==CREDITS. System reset must cover both link ends.
- valid_in may be asserted independent of ready_out. Data is not consumed unless fire.

## Test plan
- Reset, CREDITS=4: after rst deasserts → credit_cnt=4, ready_out=1, idle=1, link_valid=0, credit_err=0.
- Burst without credits: valid_in=1 with data 0x0001..0x0006 on consecutive cycles, no credit_in.
  - Exactly 0x0001..0x0004 appear on link, each one cycle after fire.
  - ready_out=0 from the cycle cnt reaches 0.
  - 0x0005 is held upstream.
- Credit resume: from the starved state, one credit_in pulse → next cycle ready_out=1; 0x0005 fires and appears on link one cycle later; cnt returns to 0.
- Full throughput: credit_in looped back from link_valid with 2-cycle delay, CREDITS=4, 100 items → one link_valid per cycle, payloads in order, no stall after the first item.
- Simultaneous events: cnt=1, fire and credit_in in the same cycle → cnt remains 1, ready_out stays 1.
- Overflow: at cnt=4 with no fire, pulse credit_in → credit_cnt stays 4, credit_err=1 and sticky; rst clears it to 0.
